// File: rtl/pqc_fifo_pkg.sv
// Shared types and constants for the coefficient FIFO read path.
package pqc_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

  localparam int COEF_Q        = 3329;
  localparam int DEF_DATAWIDTH = 13;
  localparam int DEF_FRAMELEN  = 256;
  localparam int DEF_CNTBIT    = 9;

  // Words held or in flight: buffer occupancy plus the pending BRAM read.
  function automatic logic [2:0] occ_plus_pend(input logic [1:0] occ, input logic pend);
    return {1'b0, occ} + {2'b00, pend};
  endfunction

endpackage

// File: rtl/coef_skidbuf.sv
// Two-entry in-order buffer absorbing the one-cycle BRAM read latency.
module coef_skidbuf
  import pqc_fifo_pkg::*;
#(
  parameter int W = DEF_DATAWIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_occ;
  logic         r_valid;
  logic [W-1:0] w_head_nxt;
  logic [W-1:0] w_tail_nxt;
  logic [1:0]   w_occ_nxt;

  // Head always holds the oldest word; a pop shifts the tail forward.
  always_comb begin
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    w_occ_nxt  = r_occ;
    case ({i_push, i_pop})
      2'b10: begin
        if (r_occ == 2'd0) begin
          w_head_nxt = i_din;
        end else begin
          w_tail_nxt = i_din;
        end
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b01: begin
        w_head_nxt = r_tail;
        w_occ_nxt  = r_occ - 2'd1;
      end
      2'b11: begin
        if (r_occ == 2'd2) begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_din;
        end else begin
          w_head_nxt = i_din;
        end
      end
      default: begin
        w_occ_nxt = r_occ;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
    end
  end

  assign o_valid = r_valid;
  assign o_dout  = r_head;
  assign o_occ   = r_occ;

endmodule

// File: rtl/coef_fifo_reader.sv
// Pops one frame of FRAMELEN coefficients from the FIFO as a valid/ready stream.
// Optional range check on popped coefficients: define COEF_RANGE_CHK_EN.
module coef_fifo_reader
  import pqc_fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int FRAMELEN  = DEF_FRAMELEN,
  parameter int CNTBIT    = DEF_CNTBIT,
  parameter int Q         = COEF_Q
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_frame_done,
  input  logic                 i_notempty,
  output logic                 o_fiford,
  input  logic [DATAWIDTH-1:0] i_fifo_data_out,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [DATAWIDTH-1:0] o_m_data,
  output logic                 o_m_last,
  output logic                 o_err
);

  localparam logic [CNTBIT-1:0] LP_FRAMELEN = CNTBIT'(FRAMELEN);
  localparam logic [CNTBIT-1:0] LP_LAST     = CNTBIT'(FRAMELEN - 1);
  localparam logic [CNTBIT-1:0] LP_ONE      = CNTBIT'(1);

  fsm_state_e        r_state;
  fsm_state_e        w_state_nxt;
  logic [CNTBIT-1:0] r_rdcnt;
  logic [CNTBIT-1:0] r_outcnt;
  logic              r_rd_pend;
  logic              r_frame_done;
  logic              w_start_acc;
  logic              w_pop;
  logic              w_fiford;
  logic [1:0]        w_occ;
  logic [2:0]        w_inflight;

  coef_skidbuf #(.W(DATAWIDTH)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_rd_pend),
    .i_din   (i_fifo_data_out),
    .i_pop   (w_pop),
    .o_valid (o_m_valid),
    .o_dout  (o_m_data),
    .o_occ   (w_occ)
  );

  // A read may issue only if the buffer still has room once this cycle's pop lands.
  assign w_pop      = o_m_valid & i_m_ready;
  assign w_inflight = occ_plus_pend(w_occ, r_rd_pend);
  assign w_fiford   = (r_state == ST_RUN) & i_notempty & (w_inflight <= (3'd1 + {2'b00, w_pop}));

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_fiford && (r_rdcnt == LP_LAST)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_outcnt == LP_FRAMELEN) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rdcnt      <= '0;
      r_outcnt     <= '0;
      r_rd_pend    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_fiford;
      if (w_start_acc) begin
        r_rdcnt <= '0;
      end else if (w_fiford) begin
        r_rdcnt <= r_rdcnt + LP_ONE;
      end else begin
        r_rdcnt <= r_rdcnt;
      end
      if (w_start_acc) begin
        r_outcnt <= '0;
      end else if (w_pop) begin
        r_outcnt <= r_outcnt + LP_ONE;
      end else begin
        r_outcnt <= r_outcnt;
      end
      // Lands in the same cycle DRAIN sees outcnt == FRAMELEN and returns to IDLE.
      r_frame_done <= (r_state == ST_DRAIN) & w_pop & (r_outcnt == LP_LAST);
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_fiford     = w_fiford;
  assign o_m_last     = o_m_valid & (r_outcnt == LP_LAST);

`ifdef COEF_RANGE_CHK_EN
  localparam logic [DATAWIDTH-1:0] LP_Q = DATAWIDTH'(Q);
  logic r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_pop && (o_m_data >= LP_Q)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule
